// File: rtl/compres_4to2_accum.sv
// Packet accumulator for four operands per beat. A row of 4:2 compressor cells builds a
// carry-save pair (stage 1), which is resolved and summed over the packet (stage 2).
module compres_4to2_accum #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  generate
    if (ACC_W < WIDTH + 2) begin : g_acc_w_check
      $error("compres_4to2_accum: ACC_W must be >= WIDTH+2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // One 4:2 cell: returns {cout_ext, cout_int, sum}.
  function automatic logic [2:0] cell_4to2(input logic a, input logic b, input logic c,
                                           input logic d, input logic cin);
    logic s1;
    s1 = a ^ b ^ c;
    return {(a & b) | (a & c) | (b & c), (s1 & d) | (s1 & cin) | (d & cin), s1 ^ d ^ cin};
  endfunction

  logic             stall_s;
  logic             accept_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] cint_s;
  logic             cext_top_s;
  logic [WIDTH+1:0] beatsum_s;
  logic [ACC_W-1:0] beat_ext_s;
  logic [ACC_W:0]   acc_next_s;
  logic [CNT_W-1:0] cnt_inc_s;

  logic             s1_valid_r;
  logic             s1_last_r;
  logic [WIDTH-1:0] s1_s_r;
  logic [WIDTH:0]   s1_k_r;
  logic             s1_e_r;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             out_valid_r;

  assign stall_s  = out_valid_r & ~out_ready;
  assign accept_s = in_valid & ~stall_s;
  assign in_ready = ~stall_s;

  // Compressor row; cout_ext ripples only one position into the next cell's cin.
  always_comb begin
    logic       cin_v;
    logic [2:0] cell_v;
    sum_s  = {WIDTH{1'b0}};
    cint_s = {WIDTH{1'b0}};
    cin_v  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cell_v    = cell_4to2(in_a[i], in_b[i], in_c[i], in_d[i], cin_v);
      sum_s[i]  = cell_v[0];
      cint_s[i] = cell_v[1];
      cin_v     = cell_v[2];
    end
    cext_top_s = cin_v;
  end

  assign beatsum_s  = {2'b00, s1_s_r} + {1'b0, s1_k_r} + {1'b0, s1_e_r, {WIDTH{1'b0}}};
  assign beat_ext_s = ACC_W'(beatsum_s);
  assign acc_next_s = {1'b0, acc_r} + {1'b0, beat_ext_s};
  assign cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1'b1);

  // Stage 1: capture the carry-save pair of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_s_r     <= {WIDTH{1'b0}};
      s1_k_r     <= {(WIDTH+1){1'b0}};
      s1_e_r     <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= in_last;
      s1_s_r     <= sum_s;
      s1_k_r     <= {cint_s, 1'b0};
      s1_e_r     <= cext_top_s;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: resolve and accumulate; acc_r doubles as the held output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= s1_valid_r & s1_last_r;
      if (s1_valid_r) begin
        case (state_r)
          ST_ACCUM: begin
            acc_r <= acc_next_s[ACC_W-1:0];
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | acc_next_s[ACC_W];
          end
          default: begin
            acc_r <= beat_ext_s;
            cnt_r <= CNT_W'(1'b1);
            ovf_r <= 1'b0;
          end
        endcase
        state_r <= s1_last_r ? ST_IDLE : ST_ACCUM;
      end else begin
        state_r <= state_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = acc_r;
  assign out_beats = cnt_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_compres_4to2_accum.sv
// Scoreboard bench for compres_4to2_accum: a packet model pushes expected results on the
// accepting edge of each last beat; a negedge monitor pops them when a result is taken.
module tb_compres_4to2_accum;
  localparam int W  = 8;
  localparam int AW = 10;
  localparam int CW = 4;
  localparam longint ACC_MOD = 64'd1 << AW;
  localparam longint CNT_MAX = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_beats;
  logic          out_ovf;

  compres_4to2_accum #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint beats;
    longint ovf;
  } res_t;

  res_t   exp_q[$];
  int     n_total = 0;
  int     n_bad = 0;
  longint m_sum = 0;
  longint m_cnt = 0;
  int     rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability while held, in_ready during stall, scoreboard pop on transfer.
  initial begin
    logic          held_prev;
    logic [AW-1:0] data_prev;
    logic [CW-1:0] beats_prev;
    logic          ovf_prev;
    res_t          r;
    held_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_prev = 1'b0;
      end else begin
        if (held_prev) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_data", out_data, data_prev);
          check_eq("hold_beats", out_beats, beats_prev);
          check_eq("hold_ovf", out_ovf, ovf_prev);
        end
        if (out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_result", exp_q.size(), 1);
          end else begin
            r = exp_q.pop_front();
            check_eq("data", out_data, r.data);
            check_eq("beats", out_beats, r.beats);
            check_eq("ovf", out_ovf, r.ovf);
          end
        end
        held_prev  = out_valid && !out_ready;
        data_prev  = out_data;
        beats_prev = out_beats;
        ovf_prev   = out_ovf;
      end
    end
  end

  // Present one beat from just after an edge; returns just after the edge that accepts it.
  task automatic send_beat(input int a, input int b, input int c, input int d, input bit last);
    int t;
    res_t r;
    in_valid = 1'b1;
    in_a = W'(a); in_b = W'(b); in_c = W'(c); in_d = W'(d);
    in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      check_eq("accept_timeout", t, 0);
    end else begin
      m_sum = (m_cnt == 0) ? longint'(a + b + c + d) : m_sum + longint'(a + b + c + d);
      m_cnt++;
      if (last) begin
        r.data  = m_sum % ACC_MOD;
        r.beats = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
        r.ovf   = (m_sum >= ACC_MOD) ? 1 : 0;
        exp_q.push_back(r);
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      t++;
      @(posedge clk);
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_beats", out_beats, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // Single max beat: out_valid two edges after the beat is driven.
    send_beat(255, 255, 255, 255, 1'b1);
    check_eq("lat_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_edge2", out_valid, 1);
    check_eq("lat_data", out_data, 1020);
    drain();

    // Three-beat packet.
    for (int i = 0; i < 3; i++) send_beat(1, 2, 3, 4, i == 2);
    idle(1);
    drain();

    // Overflow in a 10-bit accumulator, then a clean packet.
    send_beat(255, 255, 255, 255, 1'b0);
    send_beat(255, 255, 255, 255, 1'b1);
    send_beat(1, 2, 3, 4, 1'b1);
    idle(1);
    drain();

    // Back-pressure: out_ready low for 5 cycles during single-beat packets.
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(i, 2 * i, 3, 7 * i, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(1);
    drain();

    // Reset mid-packet discards the partial sum.
    send_beat(5, 5, 5, 5, 1'b0);
    send_beat(5, 5, 5, 5, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    exp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_beat(1, 1, 1, 1, 1'b1);
    idle(1);
    drain();

    // Random packets with random back-pressure and bubbles.
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        send_beat($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255), k == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(1);
    rdy_mode = 0;
    drain();

    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
